// File: rtl/ysyx_25070198_sram_slave.sv
// SimpleBus word-array memory slave with a fixed (or LFSR-jittered) response latency.
// Optional macro SRAM_RAND_DELAY_EN adds a 0..7 cycle random extra delay per request.
module ysyx_25070198_sram_slave #(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE      = 32'h8000_0000,
   parameter int unsigned LATENCY   = 2,
   parameter logic [3:0]  LFSR_SEED = 4'hA
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] sram_addr,
   input  logic        sram_wen,
   input  logic [31:0] sram_wdata,
   input  logic [3:0]  sram_wmask,
   input  logic        sram_reqValid,
   output logic        sram_respValid,
   output logic [31:0] sram_rdata
);

   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW   = $clog2(LATENCY + 8) + 1;
   localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

   if (LATENCY == 0 || DEPTH == 0 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("sram_slave: LATENCY must be >= 1 and DEPTH a power of two");
   end
   if (LFSR_SEED == 4'h0) begin : g_bad_seed
      $error("sram_slave: LFSR_SEED must be nonzero");
   end

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state, state_next;
   logic [CW-1:0]   cnt, cnt_next, delay;
   logic            capture, enter_resp;

   logic [31:0]     mem [DEPTH];

   logic [31:0]     off;
   logic            in_range;
   logic [AW-1:0]   idx;

   logic [AW-1:0]   cap_idx;
   logic            cap_in_range;
   logic            cap_wen;
   logic [31:0]     cap_wdata;
   logic [3:0]      cap_wmask;

   logic [AW-1:0]   eff_idx;
   logic            eff_in_range;
   logic            eff_wen;
   logic [31:0]     eff_wdata;
   logic [3:0]      eff_wmask;

   logic            unused_bits;

   // Unsigned subtraction wraps addresses below BASE to large values, so a single compare covers both bounds.
   assign off         = sram_addr - BASE;
   assign in_range    = {1'b0, off} < SPAN;
   assign idx         = off[AW+1:2];
   assign unused_bits = ^{off[31:AW+2], off[1:0]};

`ifdef SRAM_RAND_DELAY_EN
   logic [3:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) lfsr <= LFSR_SEED;
      else     lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
   end

   assign delay = CW'(LATENCY) + CW'(lfsr[2:0]);
`else
   assign delay = CW'(LATENCY);
`endif

   // With D==1 the response edge is also the capture edge, so live bus values must be used then.
   always_comb begin
      if (state == IDLE) begin
         eff_idx      = idx;
         eff_in_range = in_range;
         eff_wen      = sram_wen;
         eff_wdata    = sram_wdata;
         eff_wmask    = sram_wmask;
      end else begin
         eff_idx      = cap_idx;
         eff_in_range = cap_in_range;
         eff_wen      = cap_wen;
         eff_wdata    = cap_wdata;
         eff_wmask    = cap_wmask;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      capture    = 1'b0;
      enter_resp = 1'b0;
      case (state)
         IDLE: begin
            if (sram_reqValid) begin
               capture = 1'b1;
               if (delay == CW'(1)) begin
                  state_next = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_next = WAIT;
                  cnt_next   = delay - CW'(2);
               end
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               state_next = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_next = cnt - CW'(1);
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         sram_rdata   <= '0;
         cap_idx      <= '0;
         cap_in_range <= 1'b0;
         cap_wen      <= 1'b0;
         cap_wdata    <= '0;
         cap_wmask    <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (capture) begin
            cap_idx      <= idx;
            cap_in_range <= in_range;
            cap_wen      <= sram_wen;
            cap_wdata    <= sram_wdata;
            cap_wmask    <= sram_wmask;
         end
         if (enter_resp) sram_rdata <= eff_in_range ? mem[eff_idx] : '0;
      end
   end

   // Storage has no reset; rst still blocks the write so an aborted request leaves memory intact.
   always_ff @(posedge clk) begin
      if (!rst && enter_resp && eff_wen && eff_in_range) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (eff_wmask[i]) mem[eff_idx][8*i +: 8] <= eff_wdata[8*i +: 8];
         end
      end
   end

   assign sram_respValid = (state == RESP);

endmodule

// File: tb/tb_ysyx_25070198_sram_slave.sv
// Self-checking bench for ysyx_25070198_sram_slave: vector table, hand-written corner
// sequences and randomized traffic against an associative-array memory model.
module tb_ysyx_25070198_sram_slave;

   localparam int unsigned DEPTH   = 1024;
   localparam logic [31:0] BASE    = 32'h8000_0000;
   localparam int unsigned LATENCY = 2;

   logic        clk;
   logic        rst;
   logic [31:0] sram_addr;
   logic        sram_wen;
   logic [31:0] sram_wdata;
   logic [3:0]  sram_wmask;
   logic        sram_reqValid;
   logic        sram_respValid;
   logic [31:0] sram_rdata;

   int unsigned n_pass;
   int unsigned n_total;

   logic [31:0] mdl [int];

   ysyx_25070198_sram_slave #(
      .DEPTH(DEPTH),
      .BASE(BASE),
      .LATENCY(LATENCY),
      .LFSR_SEED(4'hA)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sram_addr(sram_addr),
      .sram_wen(sram_wen),
      .sram_wdata(sram_wdata),
      .sram_wmask(sram_wmask),
      .sram_reqValid(sram_reqValid),
      .sram_respValid(sram_respValid),
      .sram_rdata(sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      bit          chk;
      logic [31:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic check_lat(input string name, input int lat);
      bit ok;
`ifdef SRAM_RAND_DELAY_EN
      ok = (lat >= int'(LATENCY)) && (lat <= int'(LATENCY) + 7);
`else
      ok = (lat == int'(LATENCY));
`endif
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: response after %0d cycles, expected LATENCY=%0d (+0..7 with jitter)",
                    name, lat, LATENCY);
   endtask

   function automatic bit in_rng(input logic [31:0] a);
      return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * longint'(DEPTH));
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((longint'(a) - longint'(BASE)) / 4);
   endfunction

   // One request: starts on the cycle after the caller's current one, holds reqValid until respValid.
   task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m,
                         input bit scramble, output logic [31:0] rd, output int lat);
      @(posedge clk); #1;
      check("idle_no_resp", {31'b0, sram_respValid}, 32'd0);
      sram_addr     = a;
      sram_wen      = w;
      sram_wdata    = d;
      sram_wmask    = m;
      sram_reqValid = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (scramble && lat == 1) begin
            sram_addr  = a + 32'd4;
            sram_wdata = ~d;
            sram_wen   = ~w;
            sram_wmask = 4'hF;
         end
      end while (!sram_respValid && lat < 64);
      check("resp_seen", {31'b0, sram_respValid}, 32'd1);
      rd = sram_rdata;
      sram_reqValid = 1'b0;
   endtask

   task automatic xact(input string name, input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] m, input bit scramble, input bit has_exp, input logic [31:0] exp);
      logic [31:0] rd;
      logic [31:0] old;
      int          lat;
      int          k;
      do_req(a, w, d, m, scramble, rd, lat);
      check_lat({name, "_lat"}, lat);
      if (has_exp) begin
         check({name, "_rdata"}, rd, exp);
      end else if (!in_rng(a)) begin
         check({name, "_rdata_oor"}, rd, 32'h0);
      end else if (mdl.exists(widx(a))) begin
         check({name, "_rdata_mdl"}, rd, mdl[widx(a)]);
      end
      if (w && in_rng(a)) begin
         k   = widx(a);
         old = mdl.exists(k) ? mdl[k] : 32'h0;
         for (int b = 0; b < 4; b++) begin
            if (m[b]) old[8*b +: 8] = d[8*b +: 8];
         end
         if (mdl.exists(k) || m == 4'hF) mdl[k] = old;
      end
   endtask

   initial begin
      vec_t        vecs [13];
      logic [31:0] held;
      logic [31:0] a;
      bit          seen;

      n_pass  = 0;
      n_total = 0;

      vecs[0]  = '{32'h8000_0010, 1'b1, 32'h1122_3344, 4'hF, 1'b0, 32'h0};
      vecs[1]  = '{32'h8000_0010, 1'b0, 32'h0,         4'h0, 1'b1, 32'h1122_3344};
      vecs[2]  = '{32'h8000_0010, 1'b1, 32'hAABB_CCDD, 4'h5, 1'b1, 32'h1122_3344};
      vecs[3]  = '{32'h8000_0010, 1'b0, 32'h0,         4'h0, 1'b1, 32'h11BB_33DD};
      vecs[4]  = '{32'h8000_0010, 1'b1, 32'hFFFF_FFFF, 4'h0, 1'b1, 32'h11BB_33DD};
      vecs[5]  = '{32'h8000_0010, 1'b0, 32'h0,         4'h0, 1'b1, 32'h11BB_33DD};
      vecs[6]  = '{32'h8000_0000, 1'b1, 32'h0102_0304, 4'hF, 1'b0, 32'h0};
      vecs[7]  = '{32'h8000_0FFC, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0};
      vecs[8]  = '{32'h7FFF_FFFC, 1'b0, 32'h0,         4'h0, 1'b1, 32'h0};
      vecs[9]  = '{32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0};
      vecs[10] = '{32'h8000_1000, 1'b0, 32'h0,         4'h0, 1'b1, 32'h0};
      vecs[11] = '{32'h8000_0003, 1'b0, 32'h0,         4'h0, 1'b1, 32'h0102_0304};
      vecs[12] = '{32'h8000_0FFE, 1'b0, 32'h0,         4'h0, 1'b1, 32'hCAFE_F00D};

      rst           = 1'b1;
      sram_addr     = '0;
      sram_wen      = 1'b0;
      sram_wdata    = '0;
      sram_wmask    = '0;
      sram_reqValid = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("reset_respValid", {31'b0, sram_respValid}, 32'd0);
      check("reset_rdata", sram_rdata, 32'h0);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         seen |= sram_respValid;
      end
      check("no_req_no_resp", {31'b0, seen}, 32'd0);

      for (int i = 0; i < 13; i++) begin
         xact($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wen, vecs[i].wdata, vecs[i].wmask,
              1'b0, vecs[i].chk, vecs[i].exp);
      end

      // Bus inputs altered during WAIT must not affect the captured request.
      xact("pre24", 32'h8000_0024, 1'b1, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b0, 32'h0);
      xact("scr20", 32'h8000_0020, 1'b1, 32'h5566_7788, 4'hF, 1'b1, 1'b0, 32'h0);
      xact("rd20",  32'h8000_0020, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h5566_7788);
      held = sram_rdata;
      xact("rd24",  32'h8000_0024, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0BAD_F00D);
      @(posedge clk); #1;
      check("rdata_hold", sram_rdata, 32'h0BAD_F00D);
      check("rdata_changed_per_resp", {31'b0, held != sram_rdata}, 32'd1);

      // Reset while a write is waiting: no response, no storage change.
      xact("pre30", 32'h8000_0030, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 32'h0);
      @(posedge clk); #1;
      sram_addr     = 32'h8000_0030;
      sram_wen      = 1'b1;
      sram_wdata    = 32'h9ABC_DEF0;
      sram_wmask    = 4'hF;
      sram_reqValid = 1'b1;
      @(posedge clk); #1;
      rst           = 1'b1;
      sram_reqValid = 1'b0;
      seen          = sram_respValid;
      repeat (2) begin
         @(posedge clk); #1;
         seen |= sram_respValid;
      end
      rst = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         seen |= sram_respValid;
      end
      check("abort_no_resp", {31'b0, seen}, 32'd0);
      check("abort_rdata_reset", sram_rdata, 32'h0);
      xact("rd30", 32'h8000_0030, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h1234_5678);

      for (int i = 0; i < 16; i++) begin
         xact("fill", 32'h8000_0040 + 32'(4 * i), 1'b1, $urandom, 4'hF, 1'b0, 1'b0, 32'h0);
      end
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 7))
            0:       a = 32'h8000_1000 + 32'(4 * $urandom_range(0, 255));
            1:       a = 32'h7FFF_FF00 + 32'(4 * $urandom_range(0, 63));
            default: a = 32'h8000_0040 + 32'($urandom_range(0, 63));
         endcase
         xact("rand", a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
              1'b0, 1'b0, 32'h0);
      end

`ifdef SRAM_RAND_DELAY_EN
      for (int i = 0; i < 100; i++) begin
         xact("jit", 32'h8000_0040 + 32'(4 * $urandom_range(0, 15)), 1'b0, 32'h0, 4'h0,
              1'b0, 1'b0, 32'h0);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
